opc3_boot_ctrl: RTL and testbench

OPC3_BOOT_CTRL -- requirements
Module: opc3_boot_ctrl

---
 rtl/opc3_pkg.sv | 8 +
 rtl/opc3_bus_mux.sv | 22 ++
 rtl/opc3_boot_ctrl.sv | 93 +++++++++
 tb/tb_opc3_boot_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/opc3_pkg.sv
// opc3_pkg: shared state encoding and frame constants for the OPC3 boot loader
package opc3_pkg;
  localparam int HDR_LEN = 4;
  localparam int CSUM_W = 8;
  typedef enum logic [3:0] {
    ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM, RUN, ERR
  } state_e;
endpackage

// File: rtl/opc3_bus_mux.sv
// opc3_bus_mux: hands the RAM port to the CPU in RUN, to the loader otherwise
module opc3_bus_mux (
  input  logic        run,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_rnw,
  input  logic [15:0] ld_address,
  input  logic [15:0] ld_wdata,
  input  logic        ld_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] cpu_rdata
);
  always_comb begin
    mem_address = run ? cpu_address : ld_address;
    mem_wdata   = run ? cpu_wdata : ld_wdata;
    mem_we      = run ? ~cpu_rnw : ld_we;
    cpu_rdata   = mem_rdata;
  end
endmodule

// File: rtl/opc3_boot_ctrl.sv
// opc3_boot_ctrl: loads a checksummed byte frame into RAM, then releases the CPU
module opc3_boot_ctrl
  import opc3_pkg::*;
#(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_rnw,
  output logic [15:0] cpu_rdata,
  output logic        cpu_reset_b,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_e              state_q;
  logic [15:0]         addr_q, cnt_q, wdata_q;
  logic [7:0]          hi_q;
  logic [CSUM_W-1:0]   csum_q;
  logic                we_q, cpu_reset_b_q, xfer, csum_ok;
  always_comb begin
    rx_ready    = state_q != RUN && state_q != ERR;
    xfer        = rx_valid & rx_ready;
    csum_ok     = !CSUM_EN || rx_data == csum_q;
    busy        = rx_ready | we_q;
    done        = state_q == RUN;
    err         = state_q == ERR;
    cpu_reset_b = cpu_reset_b_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q        <= ADDR_H;
      addr_q         <= '0;
      cnt_q          <= '0;
      wdata_q        <= '0;
      hi_q           <= '0;
      csum_q         <= '0;
      we_q           <= 1'b0;
      cpu_reset_b_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + 16'd1;
      if (xfer) begin
        csum_q <= csum_q ^ rx_data;
        case (state_q)
          ADDR_H: begin hi_q <= rx_data; state_q <= ADDR_L; end
          ADDR_L: begin addr_q <= {hi_q, rx_data}; state_q <= CNT_H; end
          CNT_H:  begin hi_q <= rx_data; state_q <= CNT_L; end
          CNT_L: begin
            cnt_q   <= {hi_q, rx_data};
            state_q <= {hi_q, rx_data} == 16'd0 ? CSUM : DATA_H;
          end
          DATA_H: begin hi_q <= rx_data; state_q <= DATA_L; end
          DATA_L: begin
            we_q    <= 1'b1;
            wdata_q <= {hi_q, rx_data};
            cnt_q   <= cnt_q - 16'd1;
            state_q <= cnt_q == 16'd1 ? CSUM : DATA_H;
          end
          CSUM: begin
            state_q       <= csum_ok ? RUN : ERR;
            cpu_reset_b_q <= csum_ok;
          end
          default: ;
        endcase
      end
    end
  end
  // reset_b gates the strobe so a write pending at reset never reaches RAM
  opc3_bus_mux u_mux (
    .run         (state_q == RUN),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rnw     (cpu_rnw),
    .ld_address  (addr_q),
    .ld_wdata    (wdata_q),
    .ld_we       (we_q & reset_b),
    .mem_rdata   (mem_rdata),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .cpu_rdata   (cpu_rdata)
  );
endmodule

// File: tb/tb_opc3_boot_ctrl.sv
// tb_opc3_boot_ctrl: scoreboard bench checking loader writes and control outputs
module tb_opc3_boot_ctrl;
  logic        clk = 1'b0, reset_b, rx_valid, rx_ready, cpu_rnw, cpu_reset_b;
  logic        mem_we, busy, done, err;
  logic [7:0]  rx_data;
  logic [15:0] cpu_address, cpu_wdata, cpu_rdata, mem_address, mem_wdata, mem_rdata;
  logic [15:0] ram [0:65535];
  logic [31:0] exp_q [$];
  int n_vec = 0, n_err = 0;

  opc3_boot_ctrl dut (
    .clk(clk), .reset_b(reset_b), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rnw(cpu_rnw), .cpu_rdata(cpu_rdata), .cpu_reset_b(cpu_reset_b),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) ram[mem_address] <= mem_wdata;
  assign mem_rdata = ram[mem_address];

  // loader-side writes only; CPU traffic in RUN is checked directly
  always @(negedge clk) begin
    if (reset_b && !done && mem_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %h@%h want none", mem_wdata, mem_address);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_address, mem_wdata} !== e) begin
          n_err++;
          $display("FAIL write: got %h@%h want %h@%h", mem_wdata, mem_address, e[15:0], e[31:16]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!rx_ready) begin
      n_vec++; n_err++;
      $display("FAIL rx_ready_timeout: got 0 want 1");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f [0:8], input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(f[i], gap);
    rx_valid = 1'b0;
  endtask

  logic [7:0] fr_ok  [0:8] = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h52};
  logic [7:0] fr_bad [0:8] = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h53};
  logic [7:0] fr_wrp [0:8] = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; rx_valid = 1'b0; rx_data = '0;
    cpu_rnw = 1'b0; cpu_address = 16'h0100; cpu_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_cpu_reset_b", cpu_reset_b, 0); chk("rst_mem_we", mem_we, 0);
    chk("rst_rx_ready", rx_ready, 1);
    reset_b = 1'b1;

    exp_q.push_back({16'h0010, 16'h1234});
    exp_q.push_back({16'h0011, 16'hABCD});
    for (int i = 0; i < 8; i++) send_byte(fr_ok[i], 1'b0);
    chk("final_write_busy", busy, 1);
    chk("final_write_addr", mem_address, 16'h0011);
    send_byte(fr_ok[8], 1'b0);
    rx_valid = 1'b0;
    chk("ok_done", done, 1); chk("ok_cpu_reset_b", cpu_reset_b, 1);
    chk("ok_rx_ready", rx_ready, 0); chk("ok_busy", busy, 0); chk("ok_err", err, 0);
    chk("ok_queue", exp_q.size(), 0);

    cpu_address = 16'h0020; cpu_wdata = 16'h5555; cpu_rnw = 1'b0;
    #1;
    chk("cpu_we", mem_we, 1); chk("cpu_addr", mem_address, 16'h0020);
    chk("cpu_wdata", mem_wdata, 16'h5555);
    @(posedge clk); #1;
    cpu_rnw = 1'b1;
    #1;
    chk("cpu_rd_we", mem_we, 0); chk("cpu_rdata", cpu_rdata, 16'h5555);
    cpu_address = 16'h0100; cpu_rnw = 1'b0;

    do_reset();
    chk("run_rst_cpu_reset_b", cpu_reset_b, 0); chk("run_rst_done", done, 0);
    chk("run_rst_busy", busy, 1);
    exp_q.push_back({16'h0010, 16'h1234});
    exp_q.push_back({16'h0011, 16'hABCD});
    send_frame(fr_bad, 9, 1'b0);
    chk("bad_err", err, 1); chk("bad_done", done, 0);
    chk("bad_cpu_reset_b", cpu_reset_b, 0); chk("bad_rx_ready", rx_ready, 0);
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("bad_err_hold", err, 1); chk("bad_queue", exp_q.size(), 0);

    do_reset();
    exp_q.push_back({16'hFFFF, 16'h0001});
    exp_q.push_back({16'h0000, 16'h0002});
    send_frame(fr_wrp, 9, 1'b0);
    chk("wrap_done", done, 1); chk("wrap_queue", exp_q.size(), 0);

    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    chk("empty_done_early", done, 0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("empty_done", done, 1);

    do_reset();
    for (int i = 0; i < 6; i++) send_byte(fr_ok[i], 1'b1);
    do_reset();
    exp_q.push_back({16'h0010, 16'h1234});
    exp_q.push_back({16'h0011, 16'hABCD});
    send_frame(fr_ok, 9, 1'b1);
    chk("resend_done", done, 1); chk("resend_queue", exp_q.size(), 0);
    chk("image_0010", ram[16'h0010], 16'h1234); chk("image_0011", ram[16'h0011], 16'hABCD);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
